// File: rtl/pio_pkg.sv
// Shared defaults and types for the PIO instruction fetch block.
package pio_pkg;

    localparam int unsigned PIO_DATA_W = 16;
    localparam int unsigned PIO_DEPTH  = 32;
    localparam int unsigned PIO_NUM_SM = 4;
    localparam int unsigned PIO_AW     = $clog2(PIO_DEPTH);

    typedef logic [PIO_AW-1:0] addr_t;

endpackage

// File: rtl/pio_pc_ctrl.sv
// Per-state-machine program counter: jump, stall, wrap and increment selection.
module pio_pc_ctrl #(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          stall,
    input  logic          jmp_valid,
    input  logic [AW-1:0] jmp_addr,
    input  logic [AW-1:0] wrap_bottom,
    input  logic [AW-1:0] wrap_top,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next_c
);

    // Priority: disabled hold, jump (beats stall), stall hold, wrap, increment.
    // Increment wraps naturally at DEPTH because DEPTH == 2**AW.
    always_comb begin
        pc_next_c = pc;
        if (en) begin
            if (jmp_valid) begin
                pc_next_c = jmp_addr;
            end else if (stall) begin
                pc_next_c = pc;
            end else if (pc == wrap_top) begin
                pc_next_c = wrap_bottom;
            end else begin
                pc_next_c = pc + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/pio_instr_fetch.sv
// Shared instruction store with one write port and per-SM registered fetch
// ports; a same-edge write to the fetched slot is forwarded to the fetch.
module pio_instr_fetch
    import pio_pkg::*;
#(
    parameter  int unsigned DATA_W = PIO_DATA_W,
    parameter  int unsigned DEPTH  = PIO_DEPTH,
    parameter  int unsigned NUM_SM = PIO_NUM_SM,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_SM-1:0]        sm_en,
    input  logic [NUM_SM-1:0]        sm_stall,
    input  logic [NUM_SM-1:0]        jmp_valid,
    input  logic [NUM_SM*AW-1:0]     jmp_addr,
    input  logic [NUM_SM*AW-1:0]     wrap_bottom,
    input  logic [NUM_SM*AW-1:0]     wrap_top,
    output logic [NUM_SM*AW-1:0]     pc,
    output logic [NUM_SM*DATA_W-1:0] instr,
    output logic [NUM_SM-1:0]        instr_valid
);

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [AW-1:0]     pc_next [NUM_SM];

    for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
        pio_pc_ctrl #(
            .AW(AW)
        ) u_pc_ctrl (
            .clk        (clk),
            .rst        (rst),
            .en         (sm_en[i]),
            .stall      (sm_stall[i]),
            .jmp_valid  (jmp_valid[i]),
            .jmp_addr   (jmp_addr[i*AW +: AW]),
            .wrap_bottom(wrap_bottom[i*AW +: AW]),
            .wrap_top   (wrap_top[i*AW +: AW]),
            .pc         (pc[i*AW +: AW]),
            .pc_next_c  (pc_next[i])
        );
    end

    // Instruction storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                mem[a] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Fetch at pc_next so instr lines up with the registered pc; a stalled SM
    // re-reads its held slot, which makes a write to it visible next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= '0;
            instr_valid <= '0;
        end else begin
            instr_valid <= sm_en;
            for (int s = 0; s < int'(NUM_SM); s++) begin
                if (sm_en[s]) begin
                    if (wr_en && (wr_addr == pc_next[s])) begin
                        instr[s*DATA_W +: DATA_W] <= wr_data;
                    end else begin
                        instr[s*DATA_W +: DATA_W] <= mem[pc_next[s]];
                    end
                end
            end
        end
    end

endmodule

// File: doc/pio_instr_fetch.md
PIO_INSTR_FETCH -- requirements
Module: pio_instr_fetch

Interface
REQ-001 Parameter DATA_W, default 16: instruction word width in bits.
REQ-002 Parameter DEPTH, default 32: number of instruction slots; power of two, at least 2.
REQ-003 Parameter NUM_SM, default 4: number of state-machine fetch ports.
REQ-004 Derived constant AW = clog2(DEPTH): address/PC width.
REQ-005 Reset is rst, asynchronous, active-high; clock is clk.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 wr_en  in  1  instruction write strobe.
REQ-009 wr_addr  in  AW  write slot.
REQ-010 wr_data  in  DATA_W  write word.
REQ-011 sm_en  in  NUM_SM  per-SM fetch enable.
REQ-012 sm_stall  in  NUM_SM  per-SM PC hold request.
REQ-013 jmp_valid  in  NUM_SM  per-SM jump request.
REQ-014 jmp_addr  in  NUM_SM*AW  per-SM jump target, SM i in bits [i*AW +: AW].
REQ-015 wrap_bottom  in  NUM_SM*AW  per-SM wrap destination, same packing.
REQ-016 wrap_top  in  NUM_SM*AW  per-SM wrap trigger address, same packing.
REQ-017 pc  out  NUM_SM*AW  per-SM current program counter.
REQ-018 instr  out  NUM_SM*DATA_W  per-SM instruction at the current pc.
REQ-019 instr_valid  out  NUM_SM  per-SM flag: instr is valid.

Function
REQ-020 The block SHALL hold DEPTH x DATA_W storage with one synchronous write port and NUM_SM independent read ports.
REQ-021 wr_en=1 SHALL write wr_data to slot wr_addr at the clock edge.
REQ-022 Per SM i, pc_next SHALL be selected in this priority order:
  - !sm_en[i]: hold pc.
  - jmp_valid[i]: jmp_addr[i]. A jump overrides stall.
  - sm_stall[i]: hold pc.
  - pc==wrap_top[i]: wrap_bottom[i].
  - otherwise: pc+1 modulo DEPTH.
REQ-023 When wrap_top<wrap_bottom, or pc lies above wrap_top, pc SHALL increment through DEPTH-1 to 0 and wrap only on reaching wrap_top.
REQ-024 Each edge with sm_en[i]=1 SHALL register instr[i] = word at pc_next[i], so instr[i] always matches the registered pc[i]. Fetch latency is 1 cycle from the PC decision.
REQ-025 Write bypass: if wr_en=1 and wr_addr==pc_next[i] on the same edge, instr[i] SHALL capture wr_data, not the old word.
REQ-026 instr_valid[i] SHALL register sm_en[i]. With sm_en[i]=0, instr[i] and pc[i] SHALL hold their values.
REQ-027 During a stall, instr[i] SHALL re-fetch the held pc, so a write to that slot becomes visible on the next cycle.
REQ-028 Multiple SMs SHALL be allowed to read the same slot in the same cycle without conflict.
REQ-029 The block SHALL have no combinational path from any input to any output.

Reset
REQ-030 rst=1 SHALL asynchronously clear all storage slots, every pc, every instr, and every instr_valid to 0.
REQ-031 A reset asserted mid-jump, mid-stall, or mid-write SHALL discard the pending operation. The first edge after reset release SHALL behave as the first edge from pc=0.

Structure
REQ-032 Package pio_pkg SHALL hold the default DATA_W, DEPTH, and NUM_SM values and an addr_t typedef of AW bits.
REQ-033 PC control SHALL live in one sub-module, pio_pc_ctrl, instantiated NUM_SM times.
REQ-034 Storage and bypass logic SHALL live in pio_instr_fetch.

Verification
REQ-035 Wrap: write slots 0..31 with value = address+0x100; SM0 enabled with wrap_bottom=2 and wrap_top=5.
  - Required: pc sequence 0,1,2,3,4,5,2,3.
  - Required: instr sequence 0x100,0x101,0x102,0x103,0x104,0x105,0x102.
REQ-036 Jump over stall: SM1 at pc=7; assert jmp_valid=1, jmp_addr=20, and sm_stall=1 together.
  - Required: next pc=20, instr=0x114.
REQ-037 Bypass: SM2 at pc=3 and stalled; write slot 3 = 0xBEEF.
  - Required: instr=0xBEEF on the cycle after the write edge, with no stale word in between.
REQ-038 Wrap-around: wrap_bottom=0, wrap_top=1, pc jumped to 30.
  - Required: pc sequence 30,31,0,1,0.
REQ-039 Reset mid-operation: assert rst while all four SMs are running and a write is in flight.
  - Required: all pc=0, instr=0, instr_valid=0 immediately; the written slot reads 0 after release.
REQ-040 Disable/enable: deassert sm_en[3] for 3 cycles, then reassert.
  - Required: pc[3] frozen during the gap, instr_valid[3]=0 from the first edge with sm_en low.
  - Required: instr_valid[3]=1 on the first edge after reassertion, with instr matching pc.
